// File: rtl/axi4_lite_master_pkg.sv
// Shared definitions for the AXI4-Lite master: default widths, response codes, FSM states.
package axi4_lite_master_pkg;

    localparam int unsigned DEF_ADDR_W = 32;
    localparam int unsigned DEF_DATA_W = 64;
    localparam int unsigned DEF_MASK_W = DEF_DATA_W / 8;
    localparam int unsigned DEF_RESP_W = 2;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StRdAddr = 3'd1,
        StRdData = 3'd2,
        StWrReq  = 3'd3,
        StWrResp = 3'd4,
        StRsp    = 3'd5
    } state_e;

    // States in which the master is waiting on the slave.
    function automatic logic is_wait_state(input state_e s);
        return (s == StRdAddr) || (s == StRdData) || (s == StWrReq) || (s == StWrResp);
    endfunction

endpackage

// File: rtl/axi4_lite_master.sv
// Single-outstanding AXI4-Lite master: turns one core memory request into AXI channel
// transactions and returns read data or the write response.
// Optional: define AXI4_MASTER_TIMEOUT_EN to add the oTimeout sticky stall flag.
module axi4_lite_master
    import axi4_lite_master_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned MASK_W = DEF_MASK_W,
    parameter int unsigned RESP_W = DEF_RESP_W
) (
    input  logic              iClock,
    input  logic              iReset,
    input  logic              iReqValid,
    output logic              oReqReady,
    input  logic              iReqWrite,
    input  logic [ADDR_W-1:0] iReqAddr,
    input  logic [DATA_W-1:0] iReqData,
    input  logic [MASK_W-1:0] iReqMask,
    output logic              oRspValid,
    input  logic              iRspReady,
    output logic [DATA_W-1:0] oRspData,
    output logic [RESP_W-1:0] oRspResp,
    output logic              oBusy,
`ifdef AXI4_MASTER_TIMEOUT_EN
    output logic              oTimeout,
`endif
    output logic              pAXI4_ar_valid,
    output logic [ADDR_W-1:0] pAXI4_ar_bits_addr,
    input  logic              pAXI4_ar_ready,
    input  logic              pAXI4_r_valid,
    input  logic [DATA_W-1:0] pAXI4_r_bits_data,
    input  logic [RESP_W-1:0] pAXI4_r_bits_resp,
    output logic              pAXI4_r_ready,
    output logic              pAXI4_aw_valid,
    output logic [ADDR_W-1:0] pAXI4_aw_bits_addr,
    input  logic              pAXI4_aw_ready,
    output logic              pAXI4_w_valid,
    output logic [DATA_W-1:0] pAXI4_w_bits_data,
    output logic [MASK_W-1:0] pAXI4_w_bits_strb,
    input  logic              pAXI4_w_ready,
    input  logic              pAXI4_b_valid,
    input  logic [RESP_W-1:0] pAXI4_b_bits_resp,
    output logic              pAXI4_b_ready
);

    state_e            state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic [MASK_W-1:0] mask_q;
    logic              aw_done_q;
    logic              w_done_q;
    logic              aw_hs;
    logic              w_hs;

    assign aw_hs = pAXI4_aw_valid && pAXI4_aw_ready;
    assign w_hs  = pAXI4_w_valid && pAXI4_w_ready;

    // Channel payloads come straight from the latched request, so they stay stable while valid.
    assign pAXI4_ar_bits_addr = addr_q;
    assign pAXI4_aw_bits_addr = addr_q;
    assign pAXI4_w_bits_data  = data_q;
    assign pAXI4_w_bits_strb  = mask_q;
    assign oBusy              = (state_q != StIdle);

    // Transaction FSM; every handshake output is registered and set on the state transition.
    always_ff @(posedge iClock) begin
        if (iReset) begin
            state_q        <= StIdle;
            addr_q         <= '0;
            data_q         <= '0;
            mask_q         <= '0;
            aw_done_q      <= 1'b0;
            w_done_q       <= 1'b0;
            oReqReady      <= 1'b1;
            oRspValid      <= 1'b0;
            oRspData       <= '0;
            oRspResp       <= RESP_OKAY;
            pAXI4_ar_valid <= 1'b0;
            pAXI4_r_ready  <= 1'b0;
            pAXI4_aw_valid <= 1'b0;
            pAXI4_w_valid  <= 1'b0;
            pAXI4_b_ready  <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (iReqValid) begin
                        addr_q    <= iReqAddr;
                        data_q    <= iReqData;
                        mask_q    <= iReqMask;
                        oReqReady <= 1'b0;
                        if (iReqWrite) begin
                            state_q        <= StWrReq;
                            pAXI4_aw_valid <= 1'b1;
                            pAXI4_w_valid  <= 1'b1;
                            aw_done_q      <= 1'b0;
                            w_done_q       <= 1'b0;
                        end else begin
                            state_q        <= StRdAddr;
                            pAXI4_ar_valid <= 1'b1;
                        end
                    end
                end
                StRdAddr: begin
                    if (pAXI4_ar_ready) begin
                        pAXI4_ar_valid <= 1'b0;
                        pAXI4_r_ready  <= 1'b1;
                        state_q        <= StRdData;
                    end
                end
                StRdData: begin
                    if (pAXI4_r_valid) begin
                        pAXI4_r_ready <= 1'b0;
                        oRspData      <= pAXI4_r_bits_data;
                        oRspResp      <= pAXI4_r_bits_resp;
                        oRspValid     <= 1'b1;
                        state_q       <= StRsp;
                    end
                end
                StWrReq: begin
                    // AW and W complete independently, in either order or together.
                    if (aw_hs) begin
                        pAXI4_aw_valid <= 1'b0;
                        aw_done_q      <= 1'b1;
                    end
                    if (w_hs) begin
                        pAXI4_w_valid <= 1'b0;
                        w_done_q      <= 1'b1;
                    end
                    if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
                        pAXI4_b_ready <= 1'b1;
                        state_q       <= StWrResp;
                    end
                end
                StWrResp: begin
                    if (pAXI4_b_valid) begin
                        pAXI4_b_ready <= 1'b0;
                        oRspData      <= '0;
                        oRspResp      <= pAXI4_b_bits_resp;
                        oRspValid     <= 1'b1;
                        state_q       <= StRsp;
                    end
                end
                StRsp: begin
                    if (iRspReady) begin
                        oRspValid <= 1'b0;
                        oReqReady <= 1'b1;
                        state_q   <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

`ifdef AXI4_MASTER_TIMEOUT_EN
    state_e      last_q;
    logic [15:0] timer_q;

    // Counts cycles spent in the current wait state (restarts on each state change) and
    // raises a sticky flag when the slave has stalled for the full counter range.
    always_ff @(posedge iClock) begin
        if (iReset) begin
            last_q   <= StIdle;
            timer_q  <= '0;
            oTimeout <= 1'b0;
        end else begin
            last_q <= state_q;
            if (!is_wait_state(state_q)) begin
                timer_q <= '0;
            end else if (state_q != last_q) begin
                timer_q <= 16'd1;
            end else if (timer_q != 16'hFFFF) begin
                timer_q <= timer_q + 16'd1;
            end
            if (is_wait_state(state_q) && (state_q == last_q) && (timer_q == 16'hFFFF)) begin
                oTimeout <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_axi4_lite_master.sv
// Self-checking bench for axi4_lite_master with a reactive slave and a response scoreboard.
module tb_axi4_lite_master;
    import axi4_lite_master_pkg::*;

    localparam int AW = 32;
    localparam int DW = 64;
    localparam int MW = 8;
    localparam int RW = 2;

    logic          iClock = 1'b0;
    logic          iReset;
    logic          iReqValid, oReqReady, iReqWrite;
    logic [AW-1:0] iReqAddr;
    logic [DW-1:0] iReqData;
    logic [MW-1:0] iReqMask;
    logic          oRspValid, iRspReady;
    logic [DW-1:0] oRspData;
    logic [RW-1:0] oRspResp;
    logic          oBusy;
`ifdef AXI4_MASTER_TIMEOUT_EN
    logic          oTimeout;
`endif
    logic          ar_valid, ar_ready, r_valid, r_ready;
    logic [AW-1:0] ar_addr, aw_addr;
    logic [DW-1:0] r_data, w_data;
    logic [RW-1:0] r_resp, b_resp;
    logic          aw_valid, aw_ready, w_valid, w_ready, b_valid, b_ready;
    logic [MW-1:0] w_strb;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [RW-1:0] resp;
    } rsp_t;

    rsp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 iClock = ~iClock;

    axi4_lite_master dut (
        .iClock             (iClock),
        .iReset             (iReset),
        .iReqValid          (iReqValid),
        .oReqReady          (oReqReady),
        .iReqWrite          (iReqWrite),
        .iReqAddr           (iReqAddr),
        .iReqData           (iReqData),
        .iReqMask           (iReqMask),
        .oRspValid          (oRspValid),
        .iRspReady          (iRspReady),
        .oRspData           (oRspData),
        .oRspResp           (oRspResp),
        .oBusy              (oBusy),
`ifdef AXI4_MASTER_TIMEOUT_EN
        .oTimeout           (oTimeout),
`endif
        .pAXI4_ar_valid     (ar_valid),
        .pAXI4_ar_bits_addr (ar_addr),
        .pAXI4_ar_ready     (ar_ready),
        .pAXI4_r_valid      (r_valid),
        .pAXI4_r_bits_data  (r_data),
        .pAXI4_r_bits_resp  (r_resp),
        .pAXI4_r_ready      (r_ready),
        .pAXI4_aw_valid     (aw_valid),
        .pAXI4_aw_bits_addr (aw_addr),
        .pAXI4_aw_ready     (aw_ready),
        .pAXI4_w_valid      (w_valid),
        .pAXI4_w_bits_data  (w_data),
        .pAXI4_w_bits_strb  (w_strb),
        .pAXI4_w_ready      (w_ready),
        .pAXI4_b_valid      (b_valid),
        .pAXI4_b_bits_resp  (b_resp),
        .pAXI4_b_ready      (b_ready)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge iClock);
        #1;
    endtask

    // Present a request, wait for acceptance, then scramble the inputs to prove latching.
    task automatic issue(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                         input logic [MW-1:0] mask, input rsp_t exp);
        int n = 0;
        iReqValid = 1'b1;
        iReqWrite = wr;
        iReqAddr  = addr;
        iReqData  = data;
        iReqMask  = mask;
        while (!oReqReady && n < 50) begin
            step();
            n++;
        end
        if (n >= 50) check_eq("req_accept_timeout", 64'(oReqReady), 64'd1);
        step();
        iReqValid = 1'b0;
        iReqAddr  = $urandom;
        iReqData  = {$urandom, $urandom};
        iReqMask  = 8'($urandom);
        sb_q.push_back(exp);
    endtask

    // Act as the slave until oRspValid; lat counts edges from the accept edge inclusive.
    task automatic wait_rsp(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                            input logic [MW-1:0] mask, input int ar_dly, input int aw_dly,
                            input int w_dly, input int bound, output int lat, output int n_ar,
                            output int n_aw, output int n_w, output int n_rr, output int n_br,
                            output logic ok);
        lat = 1; n_ar = 0; n_aw = 0; n_w = 0; n_rr = 0; n_br = 0; ok = 1'b1;
        while (!oRspValid && lat <= bound) begin
            if (ar_valid) begin
                n_ar++;
                if (ar_addr !== addr) ok = 1'b0;
                ar_ready = (n_ar > ar_dly);
            end else ar_ready = 1'b0;
            if (aw_valid) begin
                n_aw++;
                if (aw_addr !== addr) ok = 1'b0;
                aw_ready = (n_aw > aw_dly);
            end else aw_ready = 1'b0;
            if (w_valid) begin
                n_w++;
                if (w_data !== data || w_strb !== mask) ok = 1'b0;
                w_ready = (n_w > w_dly);
            end else w_ready = 1'b0;
            if (r_ready) n_rr++;
            if (b_ready) n_br++;
            step();
            lat++;
        end
        ar_ready = 1'b0;
        aw_ready = 1'b0;
        w_ready  = 1'b0;
        if (!oRspValid) check_eq("rsp_wait_timeout", 64'(oRspValid), 64'd1);
    endtask

    // Consume the response and compare it against the scoreboard head.
    task automatic take_rsp(input string tag);
        rsp_t exp;
        if (sb_q.size() == 0) begin
            check_eq({tag, "_sb_empty"}, 64'd0, 64'd1);
            return;
        end
        exp = sb_q.pop_front();
        check_eq({tag, "_data"}, oRspData, exp.data);
        check_eq({tag, "_resp"}, 64'(oRspResp), 64'(exp.resp));
        iRspReady = 1'b1;
        step();
        iRspReady = 1'b0;
        check_eq({tag, "_done"}, 64'({oRspValid, oReqReady, oBusy}), 64'b010);
    endtask

    initial begin
        int   lat, n_ar, n_aw, n_w, n_rr, n_br;
        logic ok;

        iReset = 1'b1; iReqValid = 1'b0; iReqWrite = 1'b0; iReqAddr = '0; iReqData = '0;
        iReqMask = '0; iRspReady = 1'b0; ar_ready = 1'b0; aw_ready = 1'b0; w_ready = 1'b0;
        r_valid = 1'b1; r_data = '0; r_resp = RESP_OKAY; b_valid = 1'b1; b_resp = RESP_OKAY;
        repeat (3) step();
        iReset = 1'b0;

        check_eq("rst_ready", 64'(oReqReady), 64'd1);
        check_eq("rst_valids", 64'({oRspValid, oBusy, ar_valid, r_ready, aw_valid, w_valid,
                                    b_ready}), 64'd0);
        check_eq("rst_rsp", {oRspData[61:0], oRspResp}, 64'd0);
        check_eq("rst_regs", 64'({ar_addr, w_strb}), 64'd0);
`ifdef AXI4_MASTER_TIMEOUT_EN
        check_eq("rst_timeout", 64'(oTimeout), 64'd0);
`endif

        // Read, zero-wait slave; stray b_valid is high throughout.
        r_data = 64'h1122_3344_5566_7788;
        issue(1'b0, 32'h8000_0000, '0, '0, '{data: 64'h1122_3344_5566_7788, resp: RESP_OKAY});
        wait_rsp(32'h8000_0000, '0, '0, 0, 0, 0, 200, lat, n_ar, n_aw, n_w, n_rr, n_br, ok);
        check_eq("rd0_latency", 64'(lat), 64'd3);
        check_eq("rd0_ar_cycles", 64'(n_ar), 64'd1);
        check_eq("rd0_addr", 64'(ok), 64'd1);
        check_eq("rd0_no_bready_aw", 64'(n_br + n_aw + n_w), 64'd0);
        take_rsp("rd0");

        // Write, aw_ready delayed two cycles, w_ready immediate, SLVERR on B.
        b_resp = RESP_SLVERR;
        issue(1'b1, 32'h0000_1040, 64'hDEAD_BEEF, 8'h0F, '{data: '0, resp: RESP_SLVERR});
        wait_rsp(32'h0000_1040, 64'hDEAD_BEEF, 8'h0F, 0, 2, 0, 200, lat, n_ar, n_aw, n_w,
                 n_rr, n_br, ok);
        check_eq("wr1_latency", 64'(lat), 64'd5);
        check_eq("wr1_aw_cycles", 64'(n_aw), 64'd3);
        check_eq("wr1_w_cycles", 64'(n_w), 64'd1);
        check_eq("wr1_payload", 64'(ok), 64'd1);
        check_eq("wr1_no_rready_ar", 64'(n_rr + n_ar), 64'd0);
        take_rsp("wr1");

        // Write, AW and W complete in the same cycle.
        b_resp = RESP_OKAY;
        issue(1'b1, 32'h2000_0008, 64'h0123_4567_89AB_CDEF, 8'hF0, '{data: '0, resp: RESP_OKAY});
        wait_rsp(32'h2000_0008, 64'h0123_4567_89AB_CDEF, 8'hF0, 0, 0, 0, 200, lat, n_ar, n_aw,
                 n_w, n_rr, n_br, ok);
        check_eq("wr2_latency", 64'(lat), 64'd3);
        check_eq("wr2_aw_w_once", 64'({n_aw[7:0], n_w[7:0]}), 64'h0101);
        check_eq("wr2_bready_cycles", 64'(n_br), 64'd1);
        take_rsp("wr2");

        // Read with SLVERR and AR delayed, then response back-pressured for 5 cycles.
        r_data = 64'hA5A5_0F0F_C3C3_9696;
        r_resp = RESP_SLVERR;
        issue(1'b0, 32'h4000_0010, '0, '0, '{data: 64'hA5A5_0F0F_C3C3_9696, resp: RESP_SLVERR});
        wait_rsp(32'h4000_0010, '0, '0, 3, 0, 0, 200, lat, n_ar, n_aw, n_w, n_rr, n_br, ok);
        check_eq("rd3_latency", 64'(lat), 64'd6);
        check_eq("rd3_ar_cycles", 64'(n_ar), 64'd4);
        iReqValid = 1'b1; iReqWrite = 1'b1; iReqAddr = 32'h0000_0F00;
        iReqData = 64'h5555_AAAA; iReqMask = 8'h33;
        ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (!oRspValid || oReqReady || oRspData !== 64'hA5A5_0F0F_C3C3_9696 ||
                oRspResp !== RESP_SLVERR || aw_valid) ok = 1'b0;
            step();
        end
        check_eq("rd3_hold_stable", 64'(ok), 64'd1);
        take_rsp("rd3");
        check_eq("rd3_not_yet_accepted", 64'(aw_valid), 64'd0);
        step();
        iReqValid = 1'b0;
        sb_q.push_back('{data: '0, resp: RESP_OKAY});
        check_eq("wr4_accepted_after", 64'(aw_valid && w_valid), 64'd1);
        wait_rsp(32'h0000_0F00, 64'h5555_AAAA, 8'h33, 0, 0, 1, 200, lat, n_ar, n_aw, n_w,
                 n_rr, n_br, ok);
        check_eq("wr4_latency", 64'(lat), 64'd4);
        check_eq("wr4_payload", 64'(ok), 64'd1);
        take_rsp("wr4");

        // Reset while waiting in RD_DATA abandons the read.
        r_valid = 1'b0;
        r_resp  = RESP_OKAY;
        issue(1'b0, 32'h6000_0000, '0, '0, '{data: '0, resp: RESP_OKAY});
        check_eq("rst5_ar", 64'(ar_valid), 64'd1);
        ar_ready = 1'b1;
        step();
        ar_ready = 1'b0;
        check_eq("rst5_in_rdata", 64'({r_ready, ar_valid}), 64'b10);
        iReset = 1'b1;
        step();
        iReset = 1'b0;
        void'(sb_q.pop_back());
        check_eq("rst5_axi_idle", 64'({ar_valid, r_ready, aw_valid, w_valid, b_ready}), 64'd0);
        check_eq("rst5_req_rsp", 64'({oReqReady, oRspValid, oBusy}), 64'b100);

        // Recovery read after the abandoned one.
        r_valid = 1'b1;
        r_data  = 64'hFEED_FACE_0000_0001;
        issue(1'b0, 32'h6000_0008, '0, '0, '{data: 64'hFEED_FACE_0000_0001, resp: RESP_OKAY});
        wait_rsp(32'h6000_0008, '0, '0, 0, 0, 0, 200, lat, n_ar, n_aw, n_w, n_rr, n_br, ok);
        check_eq("rd6_latency", 64'(lat), 64'd3);
        take_rsp("rd6");

`ifdef AXI4_MASTER_TIMEOUT_EN
        // AR stalled past the counter range raises the sticky timeout.
        r_data = 64'h7777_0000_7777_0000;
        issue(1'b0, 32'h9000_0000, '0, '0, '{data: 64'h7777_0000_7777_0000, resp: RESP_OKAY});
        wait_rsp(32'h9000_0000, '0, '0, 65540, 0, 0, 70000, lat, n_ar, n_aw, n_w, n_rr,
                 n_br, ok);
        check_eq("to_flag_set", 64'(oTimeout), 64'd1);
        take_rsp("to_rd");
        check_eq("to_flag_sticky", 64'(oTimeout), 64'd1);
`endif

        check_eq("sb_drained", 64'(sb_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi4_lite_master.md
Name: axi4_lite_master

Overview:
- Upstream neighbour of the core's AXI4-Lite slave memory port.
- Converts one single-beat core-side memory request (IFU/LSU, read or write) into AXI4-Lite channel transactions.
- Returns read data or write response to the requester.
- One outstanding transaction at a time. Requests are latched, so requester signals may change after acceptance.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 64, data width
- MASK_W, 8, write-strobe width (DATA_W/8)
- RESP_W, 2, AXI response width

Ports:
- iClock  in  1  clock
- iReset  in  1  reset, synchronous, active-high
- iReqValid  in  1  request valid
- oReqReady  out  1  request accepted when iReqValid && oReqReady
- iReqWrite  in  1  1=write, 0=read
- iReqAddr  in  ADDR_W  request address
- iReqData  in  DATA_W  write data
- iReqMask  in  MASK_W  write strobes
- oRspValid  out  1  response valid
- iRspReady  in  1  response consumed
- oRspData  out  DATA_W  read data (0 for writes)
- oRspResp  out  RESP_W  AXI resp (RRESP or BRESP)
- oBusy  out  1  FSM not IDLE
- pAXI4_ar_valid/ar_bits_addr  out  1/ADDR_W
- pAXI4_ar_ready  in  1
- pAXI4_r_valid/r_bits_data/r_bits_resp  in  1/DATA_W/RESP_W
- pAXI4_r_ready  out  1
- pAXI4_aw_valid/aw_bits_addr  out  1/ADDR_W
- pAXI4_aw_ready  in  1
- pAXI4_w_valid/w_bits_data/w_bits_strb  out  1/DATA_W/MASK_W
- pAXI4_w_ready  in  1
- pAXI4_b_valid/b_bits_resp  in  1/RESP_W
- pAXI4_b_ready  out  1

Behaviour:
- Reset (synchronous, iReset high at posedge):
  - FSM goes to IDLE.
  - All valid/ready outputs are 0 except oReqReady=1.
  - oRspData=0, oRspResp=0, address/data/mask registers cleared.
- Reset mid-transaction abandons it immediately. No AXI channel is left asserted on the following cycle.
- FSM states: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, RSP.
- IDLE:
  - oReqReady=1.
  - On accept, latch addr/data/mask/write.
  - Next state is RD_ADDR (read) or WR_REQ (write).
- RD_ADDR:
  - ar_valid=1, registered.
  - On ar handshake, go to RD_DATA. ar_valid drops the next cycle.
  - Address stays stable while ar_valid && !ar_ready.
- RD_DATA:
  - r_ready=1.
  - On r handshake, latch data and resp, go to RSP.
- WR_REQ:
  - aw_valid=1 and w_valid=1 asserted together.
  - Each channel drops independently on its own handshake (tracked by flags awDone, wDone).
  - Go to WR_RESP when both are done, including both in the same cycle.
  - w handshake before aw is legal.
- WR_RESP:
  - b_ready=1.
  - On b handshake, latch resp, set oRspData=0, go to RSP.
- RSP:
  - oRspValid=1, outputs held stable.
  - On iRspReady, go to IDLE.
  - oReqReady=0 in RSP; a new request is accepted the cycle after returning to IDLE.
- Minimum latency, zero-wait slave, from request accept to oRspValid:
  - read: 3 cycles (accept, AR, R)
  - write: 3 cycles (accept, AW+W, B)
- r_ready/b_ready are asserted only in their own state. A stray r_valid or b_valid elsewhere is ignored.
- A non-OKAY resp is passed through unchanged. No retry.

Optional Feature:
- Macro AXI4_MASTER_TIMEOUT_EN.
- With it defined:
  - 16-bit counter, cleared on entering each wait state and incremented each cycle in RD_ADDR/RD_DATA/WR_REQ/WR_RESP.
  - Port oTimeout (out, 1) is added. It is a sticky flag set when the counter reaches 16'hFFFF and cleared only by reset.
  - The FSM keeps waiting; AXI protocol is not violated.
- Without it: neither the counter nor the port exists.

Decomposition:
- Shared package/Config: ADDR_W, DATA_W, MASK_W, RESP_W defaults; RESP_OKAY=2'b00, RESP_SLVERR=2'b10; FSM state encoding constants.
- No sub-module. An arbiter for IFU+LSU sharing is a separate block, out of scope.

Test Plan:
- Read, zero-wait slave: iReqAddr=0x8000_0000 → ar_addr=0x8000_0000 for exactly 1 cycle; oRspValid 3 cycles after accept with data=0x1122_3344_5566_7788, resp=0.
- Write, aw_ready delayed 2 cycles, w_ready immediate: data=0xDEAD_BEEF, mask=0x0F → w_valid drops after 1 cycle, aw_valid held for 3 cycles with stable addr; b resp=2 → oRspResp=2.
- Write, aw and w handshake in the same cycle → WR_RESP next cycle; no duplicate aw or w.
- iRspReady held 0 for 5 cycles → oRspValid and data stable throughout, oReqReady=0; the next request is accepted only after iRspReady.
- iReset asserted during RD_DATA → next cycle all AXI valid/ready outputs 0, oReqReady=1, oRspValid=0.
- (Only with AXI4_MASTER_TIMEOUT_EN) ar_ready held 0 for 65535 cycles → oTimeout rises and stays 1 after ar completes.
